// File: rtl/useq_next_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : useq_next_ctrl
// Description : Microsequencer next-address controller driving the 5-bit uPC
//               register (load_incr/upc_next), with return stack, loop counter,
//               halt state and sticky stack error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module useq_next_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             upc,
  input  logic                   uvalid,
  input  logic [2:0]             op,
  input  logic [4:0]             target,
  input  logic                   cond,
  input  logic [CW-1:0]          cnt_val,
  output logic                   load_incr,
  output logic [4:0]             upc_next,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   ovf,
  output logic                   unf
);

  localparam int c_IW  = $clog2(DEPTH);
  localparam int c_SPW = c_IW + 1;

  localparam logic [2:0] c_OP_NEXT  = 3'd0;
  localparam logic [2:0] c_OP_JMP   = 3'd1;
  localparam logic [2:0] c_OP_BRT   = 3'd2;
  localparam logic [2:0] c_OP_CALL  = 3'd3;
  localparam logic [2:0] c_OP_RET   = 3'd4;
  localparam logic [2:0] c_OP_LDCNT = 3'd5;
  localparam logic [2:0] c_OP_DJNZ  = 3'd6;
  localparam logic [2:0] c_OP_HALT  = 3'd7;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [c_SPW-1:0] r_sp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic [4:0]       r_stack [DEPTH];

  logic [4:0]       w_upc_inc;
  logic [c_SPW-1:0] w_sp_inc;
  logic [c_SPW-1:0] w_sp_dec;
  logic [CW-1:0]    w_cnt_dec;
  logic [4:0]       w_stack_top;
  logic             w_stack_full;
  logic             w_stack_empty;

  logic             w_push;
  logic             w_pop;
  logic             w_ld_cnt;
  logic             w_dec_cnt;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_upc_inc     = upc + 5'd1;
  assign w_sp_inc      = r_sp + c_SPW'(1);
  assign w_sp_dec      = r_sp - c_SPW'(1);
  assign w_cnt_dec     = r_cnt - CW'(1);
  assign w_stack_full  = (r_sp == c_SPW'(DEPTH));
  assign w_stack_empty = (r_sp == '0);
  assign w_stack_top   = r_stack[w_sp_dec[c_IW-1:0]];

  // Next-address decode; reset dominates so the uPC register sees a load of 0.
  always_comb begin
    load_incr    = 1'b0;
    upc_next     = target;
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_ld_cnt     = 1'b0;
    w_dec_cnt    = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;

    if (reset) begin
      load_incr = 1'b1;
      upc_next  = 5'd0;
    end else if (!uvalid || (r_state == ST_HALT)) begin
      load_incr = 1'b1;
      upc_next  = upc;
    end else begin
      case (op)
        c_OP_NEXT: begin
          load_incr = 1'b0;
        end
        c_OP_JMP: begin
          load_incr = 1'b1;
        end
        c_OP_BRT: begin
          load_incr = cond;
        end
        c_OP_CALL: begin
          if (w_stack_full) begin
            w_set_ovf = 1'b1;
          end else begin
            w_push    = 1'b1;
            load_incr = 1'b1;
          end
        end
        c_OP_RET: begin
          if (w_stack_empty) begin
            w_set_unf = 1'b1;
          end else begin
            w_pop     = 1'b1;
            load_incr = 1'b1;
            upc_next  = w_stack_top;
          end
        end
        c_OP_LDCNT: begin
          w_ld_cnt = 1'b1;
        end
        c_OP_DJNZ: begin
          w_dec_cnt = 1'b1;
          load_incr = (w_cnt_dec != '0);
        end
        c_OP_HALT: begin
          load_incr    = 1'b1;
          upc_next     = upc;
          w_state_next = ST_HALT;
        end
        default: begin
          load_incr = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_sp    <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_sp <= w_sp_inc;
      end else if (w_pop) begin
        r_sp <= w_sp_dec;
      end
      if (w_ld_cnt) begin
        r_cnt <= cnt_val;
      end else if (w_dec_cnt) begin
        r_cnt <= w_cnt_dec;
      end
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_set_unf) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Stack contents need no reset: an empty sp makes every entry unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[r_sp[c_IW-1:0]] <= w_upc_inc;
    end
  end

  assign halted = (r_state == ST_HALT);
  assign sp     = r_sp;
  assign ovf    = r_ovf;
  assign unf    = r_unf;

endmodule
`default_nettype wire

// File: doc/useq_next_ctrl.md
Name: useq_next_ctrl

Overview:
- Microsequencer next-address controller, the producer side of the 5-bit micro-program counter register interface.
- Decodes the sequencing field of the current microinstruction and drives load_incr/upc_next into the uPC register, which loads upc_next when load_incr=1 and increments when load_incr=0.
- Holds a return-address stack for micro-subroutines, a loop counter, a halt state, and sticky error flags.

Parameters:
- DEPTH, 4, return-stack entries (power of 2, 2..8)
- CW, 8, loop-counter width in bits

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- upc  input  5  current uPC value, fed back from the uPC register
- uvalid  input  1  current microinstruction valid
- op  input  3  sequencing opcode
- target  input  5  branch/call target address
- cond  input  1  branch condition from the datapath
- cnt_val  input  CW  loop-count load value
- load_incr  output  1  1 = uPC loads upc_next; 0 = uPC increments
- upc_next  output  5  next-address value
- halted  output  1  sequencer halted
- sp  output  clog2(DEPTH)+1  stack occupancy
- ovf  output  1  sticky stack overflow
- unf  output  1  sticky stack underflow

Behaviour:
- load_incr and upc_next are combinational from op/target/cond/upc/internal state. All state updates on posedge clk.
- Reset clears sp, loop counter, halted, ovf and unf to 0.
- Outputs while reset is asserted: load_incr=1, upc_next=0. This is consistent with the uPC register clearing to 0.
- "Hold": load_incr=1, upc_next=upc.
- "Fall through": load_incr=0, upc_next=target (don't-care value, drive target).
- Hold applies when uvalid=0 or halted=1. No state changes in that cycle.
- Opcodes, when uvalid=1 and halted=0:
  - 0 NEXT: fall through.
  - 1 JMP: load_incr=1, upc_next=target.
  - 2 BRT: if cond, jump to target; else fall through.
  - 3 CALL: push (upc+1) mod 32, sp++, jump to target. If sp==DEPTH: no push, set ovf, fall through.
  - 4 RET: jump to the top of stack, sp--. If sp==0: set unf, fall through.
  - 5 LDCNT: counter <= cnt_val, fall through.
  - 6 DJNZ: counter <= counter-1 mod 2^CW. If the decremented value is !=0, jump to target; else fall through. A counter of 0 wraps to all-ones and therefore jumps.
  - 7 HALT: hold, and halted <= 1 at the next edge. Only reset leaves the halt state.
- Stack is LIFO and addressed by sp. Only CALL and RET modify it; at most one push or pop per cycle.
- ovf and unf are sticky until reset and do not block further operation.
- Reset mid-subroutine discards all stack contents and the counter.
- Address arithmetic is 5-bit modulo. CALL at upc=31 pushes 0.

Test Plan:
- Reset, uvalid=1, op=NEXT for 3 cycles → load_incr=0 each cycle. With the uPC register connected: 0,1,2,3. Assert reset mid-run → upc=0, sp=0 immediately.
- op=JMP target=20 at upc=3 → load_incr=1, upc_next=20. Then BRT target=9: with cond=0 the uPC goes to 21; with cond=1 it goes to 9.
- CALL target=16 at upc=5 → sp=1, uPC goes to 16. NEXT brings it to 17. RET → upc_next=6, sp=0. Nested CALLs to depth 4, then a 5th CALL at upc=10 → ovf=1, sp stays 4, uPC goes to 11.
- RET with sp=0 at upc=7 → unf=1, uPC goes to 8. ovf and unf stay 1 until reset.
- LDCNT cnt_val=3, then DJNZ target=12 repeated at upc=13 → jumps twice, falls through on the 3rd pass (counter 0). LDCNT 0 then DJNZ → counter 255, jumps.
- HALT at upc=14 → load_incr=1, upc_next=14, halted=1. Subsequent ops ignored and uPC stays 14 until reset. uvalid=0 also holds upc with no state change.
